irq_encoder_16line_4line: RTL and testbench
===========================================

Name: irq_encoder_16line_4line

Overview:
- Sequential 16-line to 4-line encoder: the inverse of the 4-line to 16-line one-hot decoder used for control and enable selection.
- Latches rising edges on 16 request lines into a sticky pending register and applies a mask.
- Presents the index of the highest-priority pending line as a 4-bit code, using a valid/ack handshake.
- Sits between peripheral/event sources and the controller-sequencer, which consumes one code per ack.

Parameters:
- HIGH_WINS, 1: 1 means the highest index has priority (bit 15 first); 0 means the lowest index has priority (bit 0 first).
- MASK_RST, 16'h0000: reset value of the mask register (1 = line masked).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  16  raw request lines; a 0→1 transition is one event.
- mask_we  in  1  write strobe for the mask register.
- mask_in  in  16  new mask value, loaded when mask_we=1.
- ack  in  1  consumer accepts the presented code; meaningful only while valid=1.
- code  out  4  encoded index of the presented request.
- valid  out  1  code is valid and is held until ack.
- pending  out  16  sticky pending register (unmasked view).
- mask  out  16  current mask register.

Behaviour:
- Reset (asynchronous, active-high): pending=0, mask=MASK_RST, code=0, valid=0, FSM=IDLE, req_q=16'hFFFF. Because req_q resets to all ones, lines already high at reset produce no event.
- Edge detect: req_q <= req every cycle; rise = req & ~req_q.
- Pending update each cycle: pending <= (pending & ~clr_vec) | rise.
  - clr_vec is the one-hot of code when an ack is taken, otherwise 0.
  - Set wins: a rise on the same bit in the same cycle it is cleared leaves the bit set.
- Mask: mask <= mask_in when mask_we=1. masked = pending & ~mask. Masked lines stay pending and become eligible when unmasked.
- Priority select is combinational over masked, per HIGH_WINS. An all-zero input gives "none".
- FSM states: IDLE, PRESENT.
  - IDLE: if masked != 0, latch code <= priority index, set valid <= 1, go to PRESENT. Otherwise stay, with valid=0.
  - PRESENT: code and valid are held stable regardless of new requests or mask writes; the code is committed.
    - On ack=1: clear pending[code], set valid <= 0, go to IDLE.
    - ack while valid=0 is ignored.
- Latency and throughput:
  - req rises before edge k → pending bit set at edge k → valid=1 after edge k+1 (2 cycles).
  - After ack at edge m, valid=0 for one cycle. The next code, if any, is valid after edge m+1 (maximum one code per 2 cycles).
- Masking the currently presented line while in PRESENT does not withdraw it; ack still clears it.
- When all 16 lines rise simultaneously, they are served one per handshake in priority order, and none are lost.
- A second rise on an already-pending line before it is served merges into one event; there is no counting.
- Reset asserted mid-handshake: everything returns to reset values immediately and asynchronously, and the outstanding code is dropped.

Decomposition:
- Shared package:
  - N_LINES=16, SEL_W=4.
  - State enum {IDLE, PRESENT}.
  - One-hot-from-index function, shared conceptually with the decoder.
- Sub-module priority_encoder_16line_4line: purely combinational.
  - Inputs: in[15:0] and HIGH_WINS.
  - Outputs: idx[3:0] and any (OR of the inputs).
  - The top level instantiates it once on the masked vector.

Test Plan:
- Reset with req=16'h0010 held high → no valid ever asserts. Drop req to 0 then raise it → code=4, valid=1 exactly 2 cycles after the rise is sampled.
- HIGH_WINS=1, req rises on bits 3, 9, 15 in the same cycle → codes 15, 9, 3 in successive handshakes, ack each immediately. valid low for one cycle between codes; pending ends at 0.
- HIGH_WINS=0, same stimulus → codes 3, 9, 15.
- mask=16'h0200, bits 9 and 2 rise → code=2 only. pending keeps 16'h0200. Write mask=0 → code=9 next.
- In PRESENT with code=7, bit 7 re-rises in the same cycle as ack → pending[7] stays 1, and code=7 is presented again after the gap.
- Assert rst while valid=1, code=5 → valid=0, code=0, pending=0 in the same cycle without waiting for a clock edge. Deassert rst → idle.

Source files
------------

// File: rtl/irq_encoder_16line_4line_pkg.sv
// Shared types and helpers for the 16-line interrupt encoder.
package irq_encoder_16line_4line_pkg;

  localparam int N_LINES = 16;
  localparam int SEL_W   = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // One-hot vector from an index; the same mapping the 4-to-16 decoder uses.
  function automatic logic [N_LINES-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_LINES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/irq_encoder_16line_4line_prio.sv
// Combinational 16-to-4 priority encoder; direction chosen by HIGH_WINS.
module priority_encoder_16line_4line
  import irq_encoder_16line_4line_pkg::*;
#(
  parameter bit HIGH_WINS = 1'b1
) (
  input  logic [N_LINES-1:0] in,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  // Scan toward the winning end so the last hit seen is the highest-priority line.
  always_comb begin
    idx = '0;
    if (HIGH_WINS) begin
      for (int i = 0; i < N_LINES; i++)
        if (in[i]) idx = SEL_W'(i);
    end else begin
      for (int i = N_LINES - 1; i >= 0; i--)
        if (in[i]) idx = SEL_W'(i);
    end
  end

  assign any = |in;

endmodule

// File: rtl/irq_encoder_16line_4line.sv
// Sticky edge-latched 16-line request encoder with mask and valid/ack handshake.
module irq_encoder_16line_4line
  import irq_encoder_16line_4line_pkg::*;
#(
  parameter bit                 HIGH_WINS = 1'b1,
  parameter logic [N_LINES-1:0] MASK_RST  = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] req,
  input  logic               mask_we,
  input  logic [N_LINES-1:0] mask_in,
  input  logic               ack,
  output logic [SEL_W-1:0]   code,
  output logic               valid,
  output logic [N_LINES-1:0] pending,
  output logic [N_LINES-1:0] mask
);

  state_t             state;
  logic [N_LINES-1:0] req_q;
  logic [N_LINES-1:0] rise;
  logic [N_LINES-1:0] clr_vec;
  logic [N_LINES-1:0] masked;
  logic [SEL_W-1:0]   sel;
  logic               sel_any;
  logic               ack_take;

  // Lines already high coming out of reset must not count as events,
  // hence req_q resets to all ones.
  assign rise     = req & ~req_q;
  assign ack_take = (state == PRESENT) && ack;
  assign clr_vec  = ack_take ? onehot(code) : '0;
  assign masked   = pending & ~mask;

  priority_encoder_16line_4line #(.HIGH_WINS(HIGH_WINS)) u_prio (
    .in  (masked),
    .idx (sel),
    .any (sel_any)
  );

  // Edge history, sticky pending (a same-cycle rise beats the ack clear) and mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= '1;
      pending <= '0;
      mask    <= MASK_RST;
    end else begin
      req_q   <= req;
      pending <= (pending & ~clr_vec) | rise;
      if (mask_we) mask <= mask_in;
    end
  end

  // Handshake FSM: code is committed on entry to PRESENT and held until ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      code  <= '0;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_any) begin
            code  <= sel;
            valid <= 1'b1;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_encoder_16line_4line.sv
// Bench: two encoders (high-wins and low-wins) on shared request/mask inputs,
// checked against a line-level reference model through a code scoreboard.
module tb_irq_encoder_16line_4line;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [15:0]      req = '0;
  logic             mask_we = 1'b0;
  logic [15:0]      mask_in = '0;
  logic [1:0]       ack = '0;
  logic [1:0][3:0]  code;
  logic [1:0]       valid;
  logic [1:0][15:0] pend;
  logic [1:0][15:0] mask_o;

  int checks = 0;
  int errors = 0;
  int ack_mode = 0;  // 0 manual, 1 ack whenever valid, 2 random

  irq_encoder_16line_4line #(.HIGH_WINS(1'b1), .MASK_RST(16'h0000)) dut_hi (
    .clk(clk), .rst(rst), .req(req), .mask_we(mask_we), .mask_in(mask_in),
    .ack(ack[0]), .code(code[0]), .valid(valid[0]), .pending(pend[0]), .mask(mask_o[0])
  );

  irq_encoder_16line_4line #(.HIGH_WINS(1'b0), .MASK_RST(16'h0000)) dut_lo (
    .clk(clk), .rst(rst), .req(req), .mask_we(mask_we), .mask_in(mask_in),
    .ack(ack[1]), .code(code[1]), .valid(valid[1]), .pending(pend[1]), .mask(mask_o[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // First requesting line in priority order, or -1 when none.
  function automatic int pick(input logic [15:0] v, input bit hw);
    if (hw) begin
      for (int i = 15; i >= 0; i--) if (v[i]) return i;
    end else begin
      for (int i = 0; i < 16; i++) if (v[i]) return i;
    end
    return -1;
  endfunction

  // Reference model: per-line "seen high last cycle", outstanding events,
  // mask, and whether a code is currently offered to the consumer.
  logic [15:0]      m_prev;
  logic [1:0][15:0] m_pend;
  logic [1:0][15:0] m_mask;
  bit               m_busy [2];
  int               m_code [2];
  int               exp_q0[$], exp_q1[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prev = '1;
      m_pend = '0;
      m_mask = '0;
      for (int u = 0; u < 2; u++) begin
        m_busy[u] = 1'b0;
        m_code[u] = 0;
      end
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      for (int u = 0; u < 2; u++) begin : mdl
        int s;
        bit took;
        took = m_busy[u] && ack[u];
        s    = m_busy[u] ? -1 : pick(m_pend[u] & ~m_mask[u], (u == 0));
        if (took) m_pend[u][m_code[u]] = 1'b0;
        for (int i = 0; i < 16; i++)
          if (req[i] && !m_prev[i]) m_pend[u][i] = 1'b1;
        if (took) m_busy[u] = 1'b0;
        else if (s >= 0) begin
          m_busy[u] = 1'b1;
          m_code[u] = s;
          if (u == 0) exp_q0.push_back(s); else exp_q1.push_back(s);
        end
        if (mask_we) m_mask[u] = mask_in;
      end
      m_prev = req;
    end
  end

  // Monitor: state comparison every cycle; each newly offered code is popped
  // from the scoreboard and must stay stable until it is taken.
  bit pv [2];
  int last [2];
  int log0[$], log1[$];

  always @(negedge clk) begin
    if (rst) begin
      pv[0] = 1'b0;
      pv[1] = 1'b0;
    end else begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("valid%0d", u), valid[u], m_busy[u]);
        chk($sformatf("pending%0d", u), pend[u], m_pend[u]);
        chk($sformatf("mask%0d", u), mask_o[u], m_mask[u]);
        if (valid[u] && !pv[u]) begin
          int e;
          e = -1;
          if (u == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
          if (u == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
          if (e < 0) begin
            checks++;
            errors++;
            $display("FAIL code%0d: got %0d expected no code offered", u, code[u]);
          end else begin
            chk($sformatf("code%0d", u), code[u], e);
          end
          last[u] = e;
          if (u == 0) log0.push_back(int'(code[u])); else log1.push_back(int'(code[u]));
        end else if (valid[u]) begin
          chk($sformatf("hold%0d", u), code[u], last[u]);
        end
        pv[u] = valid[u];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    case (ack_mode)
      1:       ack = valid;
      2:       ack = 2'($urandom_range(3, 0));
      default: ack = ack;
    endcase
  endtask

  initial begin
    // Line 4 held high through reset: no event.
    rst = 1'b1; req = 16'h0010;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("held_at_reset_v0", valid[0], 1'b0);
    chk("held_at_reset_v1", valid[1], 1'b0);
    req = 16'h0000;
    repeat (2) tick();
    req = 16'h0010;
    tick();
    chk("lat_edge_k_valid", valid[0], 1'b0);
    chk("lat_edge_k_pend", pend[0], 16'h0010);
    tick();
    chk("lat_valid", valid[0], 1'b1);
    chk("lat_code", code[0], 4'd4);
    ack_mode = 1;
    req = 16'h0000;
    repeat (3) tick();
    chk("lat_drain", pend[0], 16'h0000);

    // Three simultaneous rises served in each priority order.
    log0.delete(); log1.delete();
    req = 16'h8208;
    tick();
    req = 16'h0000;
    repeat (10) tick();
    chk("trio_n_hi", log0.size(), 3);
    chk("trio_n_lo", log1.size(), 3);
    if (log0.size() == 3 && log1.size() == 3) begin
      chk("trio_hi0", log0[0], 15); chk("trio_hi1", log0[1], 9); chk("trio_hi2", log0[2], 3);
      chk("trio_lo0", log1[0], 3);  chk("trio_lo1", log1[1], 9); chk("trio_lo2", log1[2], 15);
    end
    chk("trio_pend", pend[0] | pend[1], 16'h0000);

    // Masked line stays pending until unmasked.
    mask_we = 1'b1; mask_in = 16'h0200;
    tick();
    mask_we = 1'b0;
    log0.delete(); log1.delete();
    req = 16'h0204;
    tick();
    req = 16'h0000;
    repeat (6) tick();
    chk("mask_n", log0.size(), 1);
    if (log0.size() >= 1) chk("mask_code", log0[0], 2);
    chk("mask_pend", pend[0], 16'h0200);
    mask_we = 1'b1; mask_in = 16'h0000;
    tick();
    mask_we = 1'b0;
    repeat (4) tick();
    chk("unmask_n", log0.size(), 2);
    if (log0.size() >= 2) chk("unmask_code", log0[1], 9);
    chk("unmask_pend", pend[0], 16'h0000);

    // Re-rise of the presented line in the ack cycle: set wins.
    ack_mode = 0; ack = 2'b00;
    req = 16'h0080;
    tick();
    req = 16'h0000;
    tick();
    chk("rerise_v", valid[0], 1'b1);
    chk("rerise_code", code[0], 4'd7);
    ack = 2'b11; req = 16'h0080;
    tick();
    chk("rerise_gap", valid[0], 1'b0);
    chk("rerise_pend", pend[0][7], 1'b1);
    ack = 2'b00; req = 16'h0000;
    tick();
    chk("rerise_again_v", valid[0], 1'b1);
    chk("rerise_again_code", code[0], 4'd7);
    ack_mode = 1;
    repeat (3) tick();

    // All lines at once: nothing lost.
    log0.delete(); log1.delete();
    req = 16'hFFFF;
    tick();
    req = 16'h0000;
    repeat (40) tick();
    chk("all_n_hi", log0.size(), 16);
    chk("all_n_lo", log1.size(), 16);
    chk("all_pend", pend[0] | pend[1], 16'h0000);

    // Asynchronous reset mid-handshake.
    ack_mode = 0; ack = 2'b00;
    req = 16'h0020;
    tick();
    req = 16'h0000;
    tick();
    chk("arst_pre_code", code[0], 4'd5);
    #2 rst = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("arst_valid%0d", u), valid[u], 1'b0);
      chk($sformatf("arst_code%0d", u), code[u], 4'd0);
      chk($sformatf("arst_pend%0d", u), pend[u], 16'h0000);
    end
    tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("arst_idle", valid[0] | valid[1], 1'b0);

    // Random traffic, masking and acks.
    ack_mode = 2;
    repeat (600) begin
      tick();
      if ($urandom_range(3, 0) == 0) req = req ^ (16'h0001 << $urandom_range(15, 0));
      if ($urandom_range(19, 0) == 0) begin
        mask_we = 1'b1;
        mask_in = 16'($urandom) & 16'($urandom);
      end else begin
        mask_we = 1'b0;
      end
    end

    // Drain everything.
    mask_we = 1'b1; mask_in = 16'h0000; req = 16'h0000;
    tick();
    mask_we = 1'b0;
    ack_mode = 1;
    repeat (60) tick();
    chk("drain_pend_hi", pend[0], 16'h0000);
    chk("drain_pend_lo", pend[1], 16'h0000);
    chk("drain_queue", exp_q0.size() + exp_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
